// File: rtl/sensor_cache_array_if.sv
// rtl/sensor_cache_array_if.sv - acquisition/packer bus of the per-sensor cache array
// Producer side (master) drives samples, ticks and reads; the cache (slave) drives status and bytes.
interface sensor_cache_array_if #(
   parameter int SENSOR_NUM = 20
);
   logic [SENSOR_NUM-1:0]    wr_en_i;
   logic [SENSOR_NUM*16-1:0] wr_dout_i;
   logic                     adc_acq_start_pluse_i;
   logic                     vibration_acq_start_pluse_i;
   logic                     sim_data_en_i;
   logic                     ovf_clr_i;
   logic [SENSOR_NUM-1:0]    rd_en_i;
   logic [SENSOR_NUM*8-1:0]  rd_dout_o;
   logic [SENSOR_NUM-1:0]    empty_o;
   logic [SENSOR_NUM-1:0]    prog_full_o;
   logic [SENSOR_NUM*16-1:0] rd_data_count_o;
   logic [SENSOR_NUM-1:0]    ovf_o;
   logic [SENSOR_NUM*16-1:0] drop_cnt_o;

   modport master (
      output wr_en_i, wr_dout_i, adc_acq_start_pluse_i, vibration_acq_start_pluse_i,
             sim_data_en_i, ovf_clr_i, rd_en_i,
      input  rd_dout_o, empty_o, prog_full_o, rd_data_count_o, ovf_o, drop_cnt_o
   );

   modport slave (
      input  wr_en_i, wr_dout_i, adc_acq_start_pluse_i, vibration_acq_start_pluse_i,
             sim_data_en_i, ovf_clr_i, rd_en_i,
      output rd_dout_o, empty_o, prog_full_o, rd_data_count_o, ovf_o, drop_cnt_o
   );
endinterface

// File: rtl/sensor_cache_array.sv
// rtl/sensor_cache_array.sv - per-sensor 16-bit FIFO cache read out as bytes, high byte first
// Optional simulated-data source compiled in with SENSOR_CACHE_SIM_EN.
module sensor_cache_array #(
   parameter int SENSOR_NUM       = 20,
   parameter int VIB_NUM          = 6,
   parameter int ADDR_W           = 12,
   parameter int PROG_FULL_THRESH = (1 << ADDR_W) - 16
) (
   input  logic                 sys_clk_i,
   input  logic                 rst_n_i,
   sensor_cache_array_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int WCW   = ADDR_W + 1;
   localparam int CCW   = ADDR_W + 2;
   localparam logic [ADDR_W:0] FULL_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] PF_T       = PROG_FULL_THRESH[ADDR_W:0];

`ifdef SENSOR_CACHE_SIM_EN
   logic sim_r1, sim_r2;

   always_ff @(posedge sys_clk_i) begin
      if (!rst_n_i) begin
         sim_r1 <= 1'b0;
         sim_r2 <= 1'b0;
      end else begin
         sim_r1 <= bus.sim_data_en_i;
         sim_r2 <= sim_r1;
      end
   end
`else
   logic unused_sim;
   assign unused_sim = ^{bus.sim_data_en_i, bus.adc_acq_start_pluse_i,
                         bus.vibration_acq_start_pluse_i};
`endif

   for (genvar i = 0; i < SENSOR_NUM; i++) begin : g_ch
      logic              wr_en_d, wr_en_q;
      logic [15:0]       wr_data_d, wr_data_q;
      logic [15:0]       mem [DEPTH];
      logic [ADDR_W-1:0] wr_ptr, rd_ptr;
      logic [ADDR_W:0]   words, words_nx;
      logic              phase, phase_nx;
      logic [CCW-1:0]    cnt_r, cnt_nx;
      logic              empty_r, pf_r, ovf_r;
      logic [15:0]       drop_r, drop_base;
      logic [7:0]        dout_r, byte_sel;
      logic              full, do_wr, do_drop, do_rd, do_free;

`ifdef SENSOR_CACHE_SIM_EN
      logic [7:0] sim_cnt;
      logic       tick;

      assign tick      = (i < VIB_NUM) ? bus.vibration_acq_start_pluse_i : bus.adc_acq_start_pluse_i;
      assign wr_en_d   = sim_r2 ? tick : bus.wr_en_i[i];
      assign wr_data_d = sim_r2 ? {8'(i), sim_cnt} : bus.wr_dout_i[i*16 +: 16];

      always_ff @(posedge sys_clk_i) begin
         if (!rst_n_i)
            sim_cnt <= 8'd0;
         else if (sim_r2 && wr_en_d)
            sim_cnt <= sim_cnt + 8'd1;
      end
`else
      assign wr_en_d   = bus.wr_en_i[i];
      assign wr_data_d = bus.wr_dout_i[i*16 +: 16];
`endif

      always_comb begin
         full      = (words == FULL_WORDS);
         do_wr     = wr_en_q && !full;
         do_drop   = wr_en_q && full;
         do_rd     = bus.rd_en_i[i] && !empty_r;
         do_free   = do_rd && phase;
         byte_sel  = phase ? mem[rd_ptr][7:0] : mem[rd_ptr][15:8];
         words_nx  = words + WCW'(do_wr) - WCW'(do_free);
         phase_nx  = do_rd ? ~phase : phase;
         cnt_nx    = {words_nx, 1'b0} - CCW'(phase_nx);
         // A clear in the same cycle as a drop still counts that drop.
         drop_base = bus.ovf_clr_i ? 16'd0 : drop_r;
      end

      // Memory contents survive reset; only the bookkeeping is cleared.
      always_ff @(posedge sys_clk_i) begin
         if (rst_n_i && do_wr)
            mem[wr_ptr] <= wr_data_q;
      end

      always_ff @(posedge sys_clk_i) begin
         if (!rst_n_i) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= 16'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            words     <= '0;
            phase     <= 1'b0;
            cnt_r     <= '0;
            empty_r   <= 1'b1;
            pf_r      <= 1'b0;
            ovf_r     <= 1'b0;
            drop_r    <= 16'd0;
            dout_r    <= 8'd0;
         end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            if (do_wr)
               wr_ptr <= wr_ptr + 1'b1;
            if (do_free)
               rd_ptr <= rd_ptr + 1'b1;
            if (do_rd)
               dout_r <= byte_sel;
            words   <= words_nx;
            phase   <= phase_nx;
            cnt_r   <= cnt_nx;
            empty_r <= (cnt_nx == '0);
            pf_r    <= (words_nx >= PF_T);
            ovf_r   <= (ovf_r && !bus.ovf_clr_i) || do_drop;
            if (do_drop && drop_base != 16'hFFFF)
               drop_r <= drop_base + 16'd1;
            else
               drop_r <= drop_base;
         end
      end

      assign bus.rd_dout_o[i*8 +: 8]        = dout_r;
      assign bus.empty_o[i]                 = empty_r;
      assign bus.prog_full_o[i]             = pf_r;
      assign bus.rd_data_count_o[i*16 +: 16] = 16'(cnt_r);
      assign bus.ovf_o[i]                   = ovf_r;
      assign bus.drop_cnt_o[i*16 +: 16]     = drop_r;
   end
endmodule

// File: tb/tb_sensor_cache_array.sv
// tb/tb_sensor_cache_array.sv - directed bench for sensor_cache_array (ADDR_W=4, threshold 12)
module tb_sensor_cache_array;
   localparam int N = 8;

   logic sys_clk_i = 1'b0;
   logic rst_n_i;
   int   total = 0;
   int   bad   = 0;

   always #5 sys_clk_i = ~sys_clk_i;

   sensor_cache_array_if #(.SENSOR_NUM(N)) bi ();

   sensor_cache_array #(
      .SENSOR_NUM(N), .VIB_NUM(6), .ADDR_W(4), .PROG_FULL_THRESH(12)
   ) dut (
      .sys_clk_i(sys_clk_i),
      .rst_n_i  (rst_n_i),
      .bus      (bi)
   );

   task automatic step();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dout(input int ch);
      return 32'(bi.rd_dout_o[ch*8 +: 8]);
   endfunction
   function automatic logic [31:0] cnt(input int ch);
      return 32'(bi.rd_data_count_o[ch*16 +: 16]);
   endfunction
   function automatic logic [31:0] drops(input int ch);
      return 32'(bi.drop_cnt_o[ch*16 +: 16]);
   endfunction

   initial begin
      rst_n_i = 1'b0;
      bi.wr_en_i = '0;
      bi.wr_dout_i = '0;
      bi.adc_acq_start_pluse_i = 1'b0;
      bi.vibration_acq_start_pluse_i = 1'b0;
      bi.sim_data_en_i = 1'b0;
      bi.ovf_clr_i = 1'b0;
      bi.rd_en_i = '0;
      step();
      step();
      chk("rst_empty", 32'(bi.empty_o), 32'hFF);
      chk("rst_count3", cnt(3), 0);
      chk("rst_dout3", dout(3), 0);
      chk("rst_pf", 32'(bi.prog_full_o), 0);
      chk("rst_ovf", 32'(bi.ovf_o), 0);
      rst_n_i = 1'b1;
      step();

      // single word on channel 3
      bi.wr_en_i[3] = 1'b1;
      bi.wr_dout_i[3*16 +: 16] = 16'hA55A;
      step();
      bi.wr_en_i[3] = 1'b0;
      chk("wr_empty_n1", 32'(bi.empty_o[3]), 1);
      step();
      chk("wr_empty_n2", 32'(bi.empty_o[3]), 0);
      chk("wr_count", cnt(3), 2);
      bi.rd_en_i[3] = 1'b1;
      step();
      chk("rd_hi", dout(3), 32'hA5);
      chk("rd_hi_count", cnt(3), 1);
      step();
      chk("rd_lo", dout(3), 32'h5A);
      chk("rd_lo_count", cnt(3), 0);
      chk("rd_lo_empty", 32'(bi.empty_o[3]), 1);
      step();
      bi.rd_en_i[3] = 1'b0;
      chk("rd_empty_hold", dout(3), 32'h5A);

      // fill channel 0 with 20 words, no reads
      for (int k = 0; k < 20; k++) begin
         bi.wr_en_i[0] = 1'b1;
         bi.wr_dout_i[15:0] = {8'(8'h20 + k), 8'(k)};
         step();
         if (k == 11) chk("pf_at_11", 32'(bi.prog_full_o[0]), 0);
         if (k == 12) chk("pf_at_12", 32'(bi.prog_full_o[0]), 1);
      end
      bi.wr_en_i[0] = 1'b0;
      step();
      chk("full_count", cnt(0), 32);
      chk("full_drop", drops(0), 4);
      chk("full_ovf", 32'(bi.ovf_o[0]), 1);
      chk("full_pf", 32'(bi.prog_full_o[0]), 1);
      bi.ovf_clr_i = 1'b1;
      step();
      bi.ovf_clr_i = 1'b0;
      chk("clr_ovf", 32'(bi.ovf_o[0]), 0);
      chk("clr_drop", drops(0), 0);

      // clear coinciding with a drop
      bi.wr_en_i[0] = 1'b1;
      step();
      bi.wr_en_i[0] = 1'b0;
      bi.ovf_clr_i = 1'b1;
      step();
      bi.ovf_clr_i = 1'b0;
      chk("clrdrop_ovf", 32'(bi.ovf_o[0]), 1);
      chk("clrdrop_cnt", drops(0), 1);

      // read high byte, then low-byte read coinciding with a write at full
      bi.rd_en_i[0] = 1'b1;
      step();
      bi.rd_en_i[0] = 1'b0;
      chk("rdfull_hi", dout(0), 32'h20);
      chk("rdfull_hi_cnt", cnt(0), 31);
      bi.wr_en_i[0] = 1'b1;
      step();
      bi.wr_en_i[0] = 1'b0;
      bi.rd_en_i[0] = 1'b1;
      step();
      chk("rdwr_lo", dout(0), 32'h00);
      chk("rdwr_cnt", cnt(0), 30);
      chk("rdwr_drop", drops(0), 2);
      step();
      bi.rd_en_i[0] = 1'b0;
      chk("rd_next_hi", dout(0), 32'h21);
      chk("rd_next_cnt", cnt(0), 29);

      // reset with data held
      rst_n_i = 1'b0;
      step();
      chk("mid_rst_empty", 32'(bi.empty_o), 32'hFF);
      chk("mid_rst_cnt0", cnt(0), 0);
      chk("mid_rst_drop0", drops(0), 0);
      chk("mid_rst_ovf", 32'(bi.ovf_o), 0);
      rst_n_i = 1'b1;
      step();

`ifdef SENSOR_CACHE_SIM_EN
      bi.sim_data_en_i = 1'b1;
      step();
      step();
      for (int k = 0; k < 300; k++) begin
         bi.vibration_acq_start_pluse_i = 1'b1;
         step();
         bi.vibration_acq_start_pluse_i = 1'b0;
         step();
         bi.rd_en_i[0] = 1'b1;
         step();
         chk("sim0_hi", dout(0), 32'h00);
         step();
         bi.rd_en_i[0] = 1'b0;
         chk("sim0_lo", dout(0), 32'(k % 256));
      end
      chk("sim7_empty", 32'(bi.empty_o[7]), 1);
      bi.adc_acq_start_pluse_i = 1'b1;
      step();
      bi.adc_acq_start_pluse_i = 1'b0;
      step();
      chk("sim7_cnt", cnt(7), 2);
      bi.rd_en_i[7] = 1'b1;
      step();
      chk("sim7_hi", dout(7), 32'h07);
      step();
      bi.rd_en_i[7] = 1'b0;
      chk("sim7_lo", dout(7), 32'h00);
      bi.sim_data_en_i = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
